serial_in_parallel_out_8_bits: RTL and testbench
================================================

# serial_in_parallel_out_8_bits

Serial-In-Parallel-Out (SIPO) receive shift register: the receiving end of the team's 8-bit PISO serial link. It samples a serial bit stream, LSB first, under a bit-strobe and frame-start marker, and assembles complete words. Each word goes into a holding register with a valid/ready handshake toward the parallel consumer. Sticky error flags report overrun and truncated frames.

## Interface
- WIDTH, 8, word length in bits (≥2)
- Clk_In  input  1  clock; all sampling on rising edge
- Reset_In  input  1  reset, asynchronous, active-high
- Serial_Data_In  input  1  serial bit, LSB of word first
- Serial_Valid_In  input  1  Serial_Data_In carries a bit this cycle
- Frame_Start_In  input  1  qualifies the current valid bit as bit 0 of a new word
- Parallel_Ready_In  input  1  consumer accepts held word this cycle
- Clear_Flags_In  input  1  synchronous clear of sticky flags
- Parallel_Data_Out  output  WIDTH  held received word
- Parallel_Valid_Out  output  1  Parallel_Data_Out holds an unconsumed word
- Overrun_Out  output  1  sticky: completed word dropped because holding register full
- Framing_Error_Out  output  1  sticky: frame restarted before WIDTH bits received
- SIPO_Shift_Register  output  WIDTH  debug view of the assembly register

## Operation
- States: IDLE, SHIFT. Bit counter 0..WIDTH-1.
- IDLE: Serial_Valid_In without Frame_Start_In is ignored. Serial_Valid_In & Frame_Start_In: shift bit in, count←1, go to SHIFT.
- Shifting: new bit enters at MSB, register shifts right (shift_reg ← {bit, shift_reg[WIDTH-1:1]}), so after WIDTH bits the first bit sits in bit 0.
- SHIFT, Serial_Valid_In=0: hold (gaps of any length allowed).
- SHIFT, Serial_Valid_In=1, Frame_Start_In=0: shift; count increments. On the WIDTH-th bit the word is complete: go to IDLE and transfer the assembled word (including this bit) to the holding register.
- SHIFT, Serial_Valid_In=1, Frame_Start_In=1: partial word discarded, Framing_Error_Out←1, bit taken as bit 0 of new word, count←1, stay SHIFT.
- Holding register transfer: loads if Parallel_Valid_Out=0 or Parallel_Ready_In=1 in same cycle; Parallel_Valid_Out←1. Otherwise word dropped, Overrun_Out←1, held word unchanged.
- Parallel_Ready_In with Parallel_Valid_Out=1 and no completion: Parallel_Valid_Out←0; Parallel_Data_Out keeps last value.
- Parallel_Ready_In with Parallel_Valid_Out=0: no effect.
- Clear_Flags_In clears both flags; a flag-setting event in the same cycle wins (flag stays 1).
- WIDTH=1 not supported.

## Timing
- Reset: state IDLE, count 0, SIPO_Shift_Register 0, Parallel_Data_Out 0, Parallel_Valid_Out 0, Overrun_Out 0, Framing_Error_Out 0. Reset mid-frame discards partial word and any held word immediately (asynchronous).
- Sampling on rising edge pairs with PISO negedge launch: bit is stable half a cycle before capture.
- Latency: Parallel_Valid_Out rises the cycle after the edge sampling the last bit; back-to-back frames (Frame_Start_In on the cycle immediately after the last bit) supported with no gap.
- Data accepted on rising edge where Parallel_Valid_Out & Parallel_Ready_In both high.
- Flags and outputs registered; no combinational input-to-output paths.

## Test plan
- Reset, then send 0xA5 LSB first (1,0,1,0,0,1,0,1) on consecutive cycles, Frame_Start_In on first bit, Parallel_Ready_In=0 -> Parallel_Valid_Out=1 one cycle after 8th bit, Parallel_Data_Out=0xA5, flags 0.
- Send 0x3C with 1–3-cycle random Serial_Valid_In gaps, then assert Parallel_Ready_In one cycle -> 0x3C received, Parallel_Valid_Out drops next cycle, data stays 0x3C.
- Send 0x11 (not consumed), then 0x22 -> Overrun_Out=1, Parallel_Data_Out stays 0x11; Clear_Flags_In -> Overrun_Out=0.
- Send 0x55 then 0x66 back-to-back with Parallel_Ready_In held high on completion cycle of 0x66 -> 0x66 loaded, Overrun_Out=0.
- Send 4 bits, then Frame_Start_In with new word 0x81 -> Framing_Error_Out=1, Parallel_Data_Out=0x81 after 8 further bits.
- Assert Reset_In asynchronously after 5 bits of a frame -> all outputs 0 before next edge; following full frame 0xF0 received correctly.

Source files
------------

// File: rtl/serial_in_parallel_out_8_bits.sv
// Serial-in parallel-out receiver: assembles LSB-first words under a bit strobe and
// frame-start marker, hands them off through a valid/ready holding register.
module serial_in_parallel_out_8_bits #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             Clk_In,
  input  logic             Reset_In,
  input  logic             Serial_Data_In,
  input  logic             Serial_Valid_In,
  input  logic             Frame_Start_In,
  input  logic             Parallel_Ready_In,
  input  logic             Clear_Flags_In,
  output logic [WIDTH-1:0] Parallel_Data_Out,
  output logic             Parallel_Valid_Out,
  output logic             Overrun_Out,
  output logic             Framing_Error_Out,
  output logic [WIDTH-1:0] SIPO_Shift_Register
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    count, count_nxt;
  logic [WIDTH-1:0] shift_reg, shift_nxt, shifted;
  logic             word_done;
  logic             restart;
  logic             load_hold;
  logic             drop_word;
  logic             consume;

  // New bit enters at the MSB so the first bit of a frame ends up in bit 0.
  assign shifted = {Serial_Data_In, shift_reg[WIDTH-1:1]};

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    shift_nxt = shift_reg;
    word_done = 1'b0;
    restart   = 1'b0;
    unique case (state)
      IDLE: begin
        if (Serial_Valid_In && Frame_Start_In) begin
          shift_nxt = shifted;
          count_nxt = CW'(1);
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (Serial_Valid_In) begin
          shift_nxt = shifted;
          if (Frame_Start_In) begin
            restart   = 1'b1;
            count_nxt = CW'(1);
          end else if (count == CW'(WIDTH - 1)) begin
            word_done = 1'b1;
            count_nxt = '0;
            state_nxt = IDLE;
          end else begin
            count_nxt = count + CW'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A completing word may load in the same cycle the consumer takes the previous one.
  always_comb begin
    load_hold = word_done && (!Parallel_Valid_Out || Parallel_Ready_In);
    drop_word = word_done && Parallel_Valid_Out && !Parallel_Ready_In;
    consume   = Parallel_Valid_Out && Parallel_Ready_In && !word_done;
  end

  always_ff @(posedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      state     <= IDLE;
      count     <= '0;
      shift_reg <= '0;
    end else begin
      state     <= state_nxt;
      count     <= count_nxt;
      shift_reg <= shift_nxt;
    end
  end

  always_ff @(posedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      Parallel_Data_Out  <= '0;
      Parallel_Valid_Out <= 1'b0;
    end else if (load_hold) begin
      Parallel_Data_Out  <= shifted;
      Parallel_Valid_Out <= 1'b1;
    end else if (consume) begin
      Parallel_Valid_Out <= 1'b0;
    end
  end

  // Sticky flags: a setting event in the same cycle as a clear keeps the flag set.
  always_ff @(posedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      Overrun_Out       <= 1'b0;
      Framing_Error_Out <= 1'b0;
    end else begin
      Overrun_Out       <= drop_word | (Overrun_Out & ~Clear_Flags_In);
      Framing_Error_Out <= restart   | (Framing_Error_Out & ~Clear_Flags_In);
    end
  end

  assign SIPO_Shift_Register = shift_reg;

endmodule

// File: tb/tb_serial_in_parallel_out_8_bits.sv
// Scoreboard bench for the SIPO receiver: stimulus pushes expected words, a monitor
// pops and compares each word as it is loaded into the holding register.
module tb_serial_in_parallel_out_8_bits;

  logic       clk;
  logic       rst;
  logic       sdata;
  logic       svalid;
  logic       fstart;
  logic       pready;
  logic       clr;
  logic [7:0] pdata;
  logic       pvalid;
  logic       overrun;
  logic       framing;
  logic [7:0] sreg;

  int errors;
  int checks;
  logic [7:0] exp_q[$];

  serial_in_parallel_out_8_bits #(.WIDTH(8)) dut (
    .Clk_In              (clk),
    .Reset_In            (rst),
    .Serial_Data_In      (sdata),
    .Serial_Valid_In     (svalid),
    .Frame_Start_In      (fstart),
    .Parallel_Ready_In   (pready),
    .Clear_Flags_In      (clr),
    .Parallel_Data_Out   (pdata),
    .Parallel_Valid_Out  (pvalid),
    .Overrun_Out         (overrun),
    .Framing_Error_Out   (framing),
    .SIPO_Shift_Register (sreg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, req);
    end
  endtask

  // Drives n bits of w LSB first; optional 1-3 cycle idle gaps before each bit after the first.
  task automatic send_bits(input logic [7:0] w, input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && i > 0) begin
        int g;
        g = int'($urandom_range(1, 3));
        for (int k = 0; k < g; k++) begin
          @(negedge clk);
          svalid = 1'b0;
          fstart = 1'b0;
          sdata  = 1'b0;
        end
      end
      @(negedge clk);
      sdata  = w[i];
      svalid = 1'b1;
      fstart = (i == 0);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    svalid = 1'b0;
    fstart = 1'b0;
    sdata  = 1'b0;
    pready = 1'b0;
    clr    = 1'b0;
  endtask

  task automatic ready_pulse();
    @(negedge clk);
    pready = 1'b1;
    @(negedge clk);
    pready = 1'b0;
  endtask

  // Monitor: a word is presented when valid rises, or stays high across an edge where
  // the previous word was accepted.
  initial begin
    logic vb, rb;
    forever begin
      @(posedge clk);
      vb = pvalid;
      rb = pready;
      #1;
      if (!rst && pvalid && (!vb || rb)) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got %02h expected none", pdata);
        end else begin
          check("word", pdata, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1; sdata = 1'b0; svalid = 1'b0; fstart = 1'b0; pready = 1'b0; clr = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_data",   pdata, 8'h00);
    check("reset_valid",  {7'd0, pvalid}, 8'h00);
    check("reset_flags",  {6'd0, overrun, framing}, 8'h00);
    check("reset_sreg",   sreg, 8'h00);
    rst = 1'b0;
    @(negedge clk);

    // Stray valid bit without frame start is ignored.
    svalid = 1'b1; sdata = 1'b1;
    idle();
    check("ignore_sreg", sreg, 8'h00);

    // 0xA5 on consecutive cycles, not consumed.
    exp_q.push_back(8'hA5);
    send_bits(8'hA5, 8, 1'b0);
    idle();
    check("a5_valid", {7'd0, pvalid}, 8'h01);
    check("a5_data",  pdata, 8'hA5);
    check("a5_flags", {6'd0, overrun, framing}, 8'h00);
    ready_pulse();
    check("a5_consumed", {7'd0, pvalid}, 8'h00);

    // 0x3C with gaps, then a one-cycle ready.
    exp_q.push_back(8'h3C);
    send_bits(8'h3C, 8, 1'b1);
    idle();
    check("3c_data", pdata, 8'h3C);
    ready_pulse();
    check("3c_valid_drop", {7'd0, pvalid}, 8'h00);
    check("3c_data_kept",  pdata, 8'h3C);

    // 0x11 held, 0x22 dropped as overrun.
    exp_q.push_back(8'h11);
    send_bits(8'h11, 8, 1'b0);
    idle();
    send_bits(8'h22, 8, 1'b0);
    idle();
    check("ovr_flag", {7'd0, overrun}, 8'h01);
    check("ovr_data", pdata, 8'h11);
    check("ovr_valid", {7'd0, pvalid}, 8'h01);
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    check("ovr_cleared", {7'd0, overrun}, 8'h00);
    ready_pulse();

    // 0x55 then 0x66 back-to-back; ready on 0x66 completion.
    exp_q.push_back(8'h55);
    exp_q.push_back(8'h66);
    send_bits(8'h55, 8, 1'b0);
    send_bits(8'h66, 8, 1'b0);
    pready = 1'b1;
    idle();
    check("b2b_data",    pdata, 8'h66);
    check("b2b_valid",   {7'd0, pvalid}, 8'h01);
    check("b2b_overrun", {7'd0, overrun}, 8'h00);
    ready_pulse();

    // Truncated frame after 4 bits, restarted with 0x81.
    exp_q.push_back(8'h81);
    send_bits(8'hFF, 4, 1'b0);
    send_bits(8'h81, 8, 1'b0);
    idle();
    check("frm_flag", {7'd0, framing}, 8'h01);
    check("frm_data", pdata, 8'h81);
    check("frm_ovr",  {7'd0, overrun}, 8'h00);

    // Asynchronous reset after 5 bits of a frame.
    send_bits(8'hC3, 5, 1'b0);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_data",  pdata, 8'h00);
    check("arst_sreg",  sreg, 8'h00);
    check("arst_ctl",   {5'd0, pvalid, overrun, framing}, 8'h00);
    idle();
    rst = 1'b0;
    idle();

    exp_q.push_back(8'hF0);
    send_bits(8'hF0, 8, 1'b0);
    idle();
    check("f0_data",  pdata, 8'hF0);
    check("f0_valid", {7'd0, pvalid}, 8'h01);
    check("f0_sreg",  sreg, 8'hF0);

    repeat (4) @(negedge clk);
    check("queue_empty", 8'(exp_q.size()), 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
